// File: rtl/string_hw_avalon_bridge.sv
// Avalon-MM slave front end for the string compare/upper/lower accelerator.
// Holds operand buffers A/B, captures the result and runs a watchdog-guarded go/done handshake.
module string_hw_avalon_bridge #(
    parameter int NCHARS  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          avs_address,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    input  logic [3:0]          avs_byteenable,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    output logic                irq,
    output logic                acc_go,
    output logic [3:0]          acc_index,
    output logic [NCHARS*8-1:0] acc_a,
    output logic [NCHARS*8-1:0] acc_b,
    input  logic [NCHARS*8-1:0] acc_result,
    input  logic                acc_done
);

    localparam int NWORDS = NCHARS / 4;
    localparam int CW     = $clog2(NCHARS);
    localparam int WDW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [WDW-1:0] wdog_r, wdog_nxt_s;
    logic [7:0]     a_r   [NCHARS];
    logic [7:0]     b_r   [NCHARS];
    logic [7:0]     res_r [NCHARS];
    logic [3:0]     index_r, acc_index_r;
    logic           ien_r, done_r, tmo_r, wrerr_r;
    logic [31:0]    readdata_r, rd_mux_s;

    logic           busy_s, ctrl_wr_s, status_wr_s, a_wr_s, b_wr_s, word_ok_s;
    logic           start_s, wr_drop_s, capture_s, set_done_s, set_tmo_s;
    logic [CW-1:0]  cbase_s;

    // Address decode and write qualification
    always_comb begin
        busy_s      = (state_r != ST_IDLE);
        ctrl_wr_s   = avs_write && (avs_address == 6'h00);
        status_wr_s = avs_write && (avs_address == 6'h01);
        word_ok_s   = ({29'd0, avs_address[2:0]} < 32'(NWORDS));
        a_wr_s      = avs_write && (avs_address[5:3] == 3'b001) && word_ok_s;
        b_wr_s      = avs_write && (avs_address[5:3] == 3'b010) && word_ok_s;
        start_s     = ctrl_wr_s && avs_writedata[0] && !busy_s;
        wr_drop_s   = busy_s && (ctrl_wr_s || a_wr_s || b_wr_s);
        cbase_s     = CW'({avs_address[2:0], 2'b00});
    end

    // Next-state, watchdog and handshake event logic
    always_comb begin
        state_nxt_s = state_r;
        wdog_nxt_s  = wdog_r;
        capture_s   = 1'b0;
        set_done_s  = 1'b0;
        set_tmo_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_RUN;
                    wdog_nxt_s  = WDW'(TIMEOUT);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // done is checked first so it wins over a same-cycle expiry
                if (acc_done) begin
                    capture_s   = 1'b1;
                    set_done_s  = 1'b1;
                    state_nxt_s = ST_RELEASE;
                    wdog_nxt_s  = WDW'(TIMEOUT);
                end else if (wdog_r <= WDW'(1)) begin
                    set_tmo_s   = 1'b1;
                    state_nxt_s = ST_RELEASE;
                    wdog_nxt_s  = WDW'(TIMEOUT);
                end else begin
                    wdog_nxt_s  = wdog_r - WDW'(1);
                end
            end
            ST_RELEASE: begin
                if (!acc_done) begin
                    state_nxt_s = ST_IDLE;
                end else if (wdog_r <= WDW'(1)) begin
                    set_tmo_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    wdog_nxt_s  = wdog_r - WDW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and watchdog registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            wdog_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            wdog_r  <= wdog_nxt_s;
        end
    end

    // CTRL fields and sticky STATUS flags; hardware set beats a W1C in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index_r     <= 4'd0;
            acc_index_r <= 4'd0;
            ien_r       <= 1'b0;
            done_r      <= 1'b0;
            tmo_r       <= 1'b0;
            wrerr_r     <= 1'b0;
        end else begin
            if (ctrl_wr_s && !busy_s) begin
                index_r <= avs_writedata[7:4];
                ien_r   <= avs_writedata[8];
            end
            if (start_s) begin
                acc_index_r <= avs_writedata[7:4];
            end
            done_r  <= set_done_s | (done_r & ~(status_wr_s & avs_writedata[1]) & ~start_s);
            tmo_r   <= set_tmo_s  | (tmo_r  & ~(status_wr_s & avs_writedata[2]) & ~start_s);
            wrerr_r <= wr_drop_s  | (wrerr_r & ~(status_wr_s & avs_writedata[3]));
        end
    end

    // Operand buffers with per-lane byte enables, and result capture on done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCHARS; c++) begin
                a_r[c]   <= 8'd0;
                b_r[c]   <= 8'd0;
                res_r[c] <= 8'd0;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (a_wr_s && !busy_s && avs_byteenable[j]) begin
                    a_r[cbase_s + CW'(j)] <= avs_writedata[8*j +: 8];
                end
                if (b_wr_s && !busy_s && avs_byteenable[j]) begin
                    b_r[cbase_s + CW'(j)] <= avs_writedata[8*j +: 8];
                end
            end
            if (capture_s) begin
                for (int c = 0; c < NCHARS; c++) begin
                    res_r[c] <= acc_result[(NCHARS-1-c)*8 +: 8];
                end
            end
        end
    end

    // Read data multiplexer over the pre-write register values
    always_comb begin
        rd_mux_s = 32'd0;
        case (avs_address[5:3])
            3'b000: begin
                if (avs_address[2:0] == 3'd0) begin
                    rd_mux_s = {23'd0, ien_r, index_r, 4'b0000};
                end else if (avs_address[2:0] == 3'd1) begin
                    rd_mux_s = {28'd0, wrerr_r, tmo_r, done_r, busy_s};
                end else begin
                    rd_mux_s = 32'd0;
                end
            end
            3'b001, 3'b010, 3'b011: begin
                if (word_ok_s) begin
                    for (int j = 0; j < 4; j++) begin
                        if (avs_address[5:3] == 3'b001) begin
                            rd_mux_s[8*j +: 8] = a_r[cbase_s + CW'(j)];
                        end else if (avs_address[5:3] == 3'b010) begin
                            rd_mux_s[8*j +: 8] = b_r[cbase_s + CW'(j)];
                        end else begin
                            rd_mux_s[8*j +: 8] = res_r[cbase_s + CW'(j)];
                        end
                    end
                end else begin
                    rd_mux_s = 32'd0;
                end
            end
            default: begin
                rd_mux_s = 32'd0;
            end
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata_r <= 32'd0;
        end else if (avs_read) begin
            readdata_r <= rd_mux_s;
        end else begin
            readdata_r <= readdata_r;
        end
    end

    for (genvar c = 0; c < NCHARS; c++) begin : g_pack
        assign acc_a[(NCHARS-1-c)*8 +: 8] = a_r[c];
        assign acc_b[(NCHARS-1-c)*8 +: 8] = b_r[c];
    end

    assign avs_readdata = readdata_r;
    assign acc_go       = (state_r == ST_RUN);
    assign acc_index    = acc_index_r;
    assign irq          = ien_r & (done_r | tmo_r);

endmodule
